// File: rtl/add_accumulator_4bit_pkg.sv
// Shared constants for the 4-bit add accumulator and its arithmetic blocks.
//   OpWidth : operand width in bits
//   AccWidth: accumulator/result width (two nibbles)
//   state_e : FSM state encoding
package add_accumulator_4bit_pkg;

    localparam int unsigned OpWidth  = 4;
    localparam int unsigned AccWidth = 2 * OpWidth;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StAccum = 2'b01,
        StHold  = 2'b10
    } state_e;

endpackage

// File: rtl/ripple_carry_adder_4bit.sv
// Ripple-carry adder, OpWidth bits wide, built from full-adder cells.
// Ports:
//   a_i, b_i : addends
//   c0_i     : carry in
//   sum_o    : sum bits
//   c4_o     : carry out of the most significant cell
module ripple_carry_adder_4bit
    import add_accumulator_4bit_pkg::*;
(
    input  logic [OpWidth-1:0] a_i,
    input  logic [OpWidth-1:0] b_i,
    input  logic               c0_i,
    output logic [OpWidth-1:0] sum_o,
    output logic               c4_o
);

    logic [OpWidth:0] carry;

    assign carry[0] = c0_i;

    for (genvar i = 0; i < OpWidth; i++) begin : g_fa
        assign sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
        assign carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end

    assign c4_o = carry[OpWidth];

endmodule

// File: rtl/add_accumulator_4bit.sv
// Accumulates `count` unsigned 4-bit operands into an 8-bit total.
// The low nibble is summed by a ripple-carry adder; its carry-out
// increments the high nibble.
// Ports:
//   clock, reset         : rising-edge clock, async active-high reset
//   start, count         : begin accumulation of `count` operands (IDLE only)
//   in_valid/in_ready    : operand handshake, in_data is the operand
//   out_valid/out_ready  : result handshake, result is the total
//   busy                 : high whenever not IDLE
module add_accumulator_4bit
    import add_accumulator_4bit_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [OpWidth-1:0]  count,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OpWidth-1:0]  in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [AccWidth-1:0] result,
    output logic                busy
);

    state_e               state_q;
    logic [AccWidth-1:0]  acc_q;
    logic [OpWidth-1:0]   remaining_q;

    logic [OpWidth-1:0]   lo_sum;
    logic                 lo_carry;

    ripple_carry_adder_4bit u_adder (
        .a_i   (acc_q[OpWidth-1:0]),
        .b_i   (in_data),
        .c0_i  (1'b0),
        .sum_o (lo_sum),
        .c4_o  (lo_carry)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            remaining_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        acc_q <= '0;
                        if (count != '0) begin
                            remaining_q <= count;
                            state_q     <= StAccum;
                        end else begin
                            state_q <= StHold;
                        end
                    end
                end
                StAccum: begin
                    // in_ready is high throughout ACCUM, so in_valid alone marks a beat.
                    if (in_valid) begin
                        acc_q[OpWidth-1:0]        <= lo_sum;
                        acc_q[AccWidth-1:OpWidth] <= acc_q[AccWidth-1:OpWidth]
                                                     + {{(OpWidth-1){1'b0}}, lo_carry};
                        remaining_q               <= remaining_q - 1'b1;
                        if (remaining_q == OpWidth'(1)) begin
                            state_q <= StHold;
                        end
                    end
                end
                StHold: begin
                    if (out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Outputs decode the state register only; no input reaches an output combinationally.
    assign in_ready  = (state_q == StAccum);
    assign out_valid = (state_q == StHold);
    assign busy      = (state_q != StIdle);
    assign result    = acc_q;

endmodule

// File: tb/tb_add_accumulator_4bit.sv
// Directed self-checking bench for add_accumulator_4bit.
module tb_add_accumulator_4bit;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] count;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    add_accumulator_4bit dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .count     (count),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check the three status outputs together as {in_ready, out_valid, busy}.
    task automatic check_flags(input string tag, input logic [2:0] exp);
        check(tag, {5'b0, in_ready, out_valid, busy}, {5'b0, exp});
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        count     = 4'd0;
        in_valid  = 1'b0;
        in_data   = 4'd0;
        out_ready = 1'b0;
        #1;
        check_flags("reset_flags", 3'b000);
        check("reset_result", result, 8'h00);
        step();
        step();
        reset = 1'b0;
        step();
        check_flags("idle_after_reset", 3'b000);

        // count=3: 5, 7, 9 back-to-back -> 0x15
        start = 1'b1; count = 4'd3;
        step();
        start = 1'b0;
        check_flags("s1_accum_flags", 3'b101);
        in_valid = 1'b1; in_data = 4'd5;
        step();
        check("s1_beat1", result, 8'h05);
        in_data = 4'd7;
        step();
        check("s1_beat2", result, 8'h0C);
        check_flags("s1_still_accum", 3'b101);
        in_data = 4'd9;
        step();
        in_valid = 1'b0;
        check_flags("s1_hold_flags", 3'b011);
        check("s1_result", result, 8'h15);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_flags("s1_back_idle", 3'b000);
        check("s1_result_kept", result, 8'h15);

        // count=15, all 15 -> 0xE1, high nibble tracks every carry
        start = 1'b1; count = 4'd15;
        step();
        start = 1'b0;
        check("s2_cleared", result, 8'h00);
        in_valid = 1'b1; in_data = 4'd15;
        for (int k = 1; k <= 15; k++) begin
            step();
            check($sformatf("s2_beat%0d", k), result, 8'(15 * k));
        end
        in_valid = 1'b0;
        check_flags("s2_hold_flags", 3'b011);
        check("s2_result", result, 8'hE1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // count=0 -> HOLD next cycle with cleared total
        start = 1'b1; count = 4'd0;
        step();
        start = 1'b0;
        check_flags("s3_hold_flags", 3'b011);
        check("s3_result", result, 8'h00);
        step();
        check_flags("s3_stays_hold", 3'b011);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_flags("s3_back_idle", 3'b000);

        // count=2: 4, gap of two idle cycles, 3; HOLD stalls 5 cycles
        start = 1'b1; count = 4'd2;
        step();
        start = 1'b0;
        in_valid = 1'b1; in_data = 4'd4;
        step();
        in_valid = 1'b0; in_data = 4'd9;
        step();
        check("s4_gap1", result, 8'h04);
        step();
        check("s4_gap2", result, 8'h04);
        check_flags("s4_gap_flags", 3'b101);
        in_valid = 1'b1; in_data = 4'd3;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check_flags($sformatf("s4_hold_flags%0d", k), 3'b011);
            check($sformatf("s4_hold_result%0d", k), result, 8'h07);
            step();
        end
        // start coincident with the HOLD->IDLE edge must be ignored
        out_ready = 1'b1; start = 1'b1; count = 4'd1;
        step();
        out_ready = 1'b0; start = 1'b0;
        check_flags("s4_back_idle", 3'b000);
        step();
        check_flags("s4_start_not_honoured", 3'b000);
        check("s4_result_kept", result, 8'h07);

        // start pulses in ACCUM and HOLD are ignored
        start = 1'b1; count = 4'd2;
        step();
        count = 4'd5;
        step();
        start = 1'b0;
        check_flags("s6_accum_start", 3'b101);
        check("s6_accum_result", result, 8'h00);
        in_valid = 1'b1; in_data = 4'd8;
        step();
        in_data = 4'd1;
        step();
        in_valid = 1'b0;
        check_flags("s6_hold_after_two", 3'b011);
        check("s6_result", result, 8'h09);
        start = 1'b1; count = 4'd0;
        step();
        start = 1'b0;
        check_flags("s6_hold_start", 3'b011);
        check("s6_hold_result", result, 8'h09);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // count=4, async reset after 2 beats, then count=1 with 6
        start = 1'b1; count = 4'd4;
        step();
        start = 1'b0;
        in_valid = 1'b1; in_data = 4'd1;
        step();
        in_data = 4'd2;
        step();
        check("s5_partial", result, 8'h03);
        #2;
        reset = 1'b1;
        #1;
        check_flags("s5_async_flags", 3'b000);
        check("s5_async_result", result, 8'h00);
        step();
        reset = 1'b0;
        step();
        in_valid = 1'b0;
        check_flags("s5_idle_no_start", 3'b000);
        start = 1'b1; count = 4'd1;
        step();
        start = 1'b0;
        in_valid = 1'b1; in_data = 4'd6;
        step();
        in_valid = 1'b0;
        check_flags("s5_hold_flags", 3'b011);
        check("s5_result", result, 8'h06);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_flags("s5_back_idle", 3'b000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
